// File: rtl/mem_route_pkg.sv
// mem_route_pkg: constants shared by the memory output router.
// Phase request code, null tag and drop-counter width.
package mem_route_pkg;
  localparam logic [1:0] PH_REQ   = 2'b10;
  localparam logic [1:0] TAG_NULL = 2'b00;
  localparam int         DROP_W   = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;
endpackage

// File: rtl/mem_out_router_fifo.sv
// sync_fifo: DEPTH-entry FIFO, one push and one pop per cycle.
// Ports: clk, rst, push, pop, din, dout (0 when empty), full, empty.
module sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rp];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
endmodule

// File: rtl/mem_out_router.sv
// mem_out_router: routes memory words to NCH buffered channels.
// Ports: mem_data/valid/ready in, ph codes, out_data/valid/ready,
// ch_full per channel, saturating drop_cnt of absorbed null words.
module mem_out_router
  import mem_route_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      mem_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [2*NCH-1:0]  ph,
  output logic [NCH*W-1:0]  out_data,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ready,
  output logic [NCH-1:0]    ch_full,
  output logic [DROP_W-1:0] drop_cnt
);
  localparam int SW = $clog2(NCH);

  logic [SW-1:0]  sel;
  logic           has_sel;
  logic           is_null;
  logic           accept;
  logic [NCH-1:0] empty;

  // Scan high to low so the lowest requesting index wins.
  always_comb begin
    has_sel = 1'b0;
    sel     = '0;
    for (int i = NCH-1; i >= 0; i--) begin
      if (ph[2*i +: 2] == PH_REQ) begin
        has_sel = 1'b1;
        sel     = SW'(i);
      end
    end
  end

  assign is_null   = (mem_data[W-1 -: 2] == TAG_NULL);
  // Depends on registered ch_full only, never on out_ready.
  assign mem_ready = !rst && mem_valid &&
                     (is_null || (has_sel && !ch_full[sel]));
  assign accept    = mem_valid && mem_ready;
  assign out_valid = ~empty;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic push;
    logic pop;
    assign push = accept && !is_null && has_sel &&
                  (sel == SW'(g));
    assign pop  = out_valid[g] && out_ready[g];

    sync_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (mem_data),
      .dout  (out_data[W*g +: W]),
      .full  (ch_full[g]),
      .empty (empty[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (accept && is_null && drop_cnt != DROP_MAX) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_out_router.sv
// tb_mem_out_router: directed scoreboard bench for mem_out_router.
// Inputs change 1 time unit after posedge; outputs sampled at negedge.
module tb_mem_out_router;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [3:0]  ph;
  logic [31:0] out_data;
  logic [1:0]  out_valid;
  logic [1:0]  out_ready;
  logic [1:0]  ch_full;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  mem_out_router #(.NCH(2), .W(16), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_data  (mem_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .ph        (ph),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ch_full   (ch_full),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every pop is compared with the oldest expected word.
  always @(negedge clk) begin
    if (out_valid[0] && out_ready[0]) begin
      if (q0.size() == 0) chk("ch0_unexpected_pop", 32'(out_data[15:0]), 32'hDEAD);
      else chk("ch0_pop", 32'(out_data[15:0]), 32'(q0.pop_front()));
    end
    if (out_valid[1] && out_ready[1]) begin
      if (q1.size() == 0) chk("ch1_unexpected_pop", 32'(out_data[31:16]), 32'hDEAD);
      else chk("ch1_pop", 32'(out_data[31:16]), 32'(q1.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // exp_ch < 0: no channel expected to receive the word.
  task automatic send(input logic [15:0] d, input logic [3:0] p,
                      input logic exp_rdy, input int exp_ch);
    mem_valid = 1'b1;
    mem_data  = d;
    ph        = p;
    @(negedge clk);
    chk("mem_ready", 32'(mem_ready), 32'(exp_rdy));
    if (exp_rdy && exp_ch == 0) q0.push_back(d);
    if (exp_rdy && exp_ch == 1) q1.push_back(d);
    tick();
    mem_valid = 1'b0;
  endtask

  task automatic drain(input logic [1:0] r, input int n);
    out_ready = r;
    repeat (n) tick();
    out_ready = 2'b00;
  endtask

  initial begin
    rst = 1'b1; mem_valid = 1'b1; mem_data = 16'hC0DE;
    ph = 4'b0010; out_ready = 2'b00;
    @(negedge clk);
    chk("rst_mem_ready", 32'(mem_ready), 32'h0);
    tick(); tick();
    rst = 1'b0; mem_valid = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_ch_full", 32'(ch_full), 32'h0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);

    // 1. basic route to ch1
    send(16'hC123, 4'b1000, 1'b1, 1);
    chk("t1_out_valid", 32'(out_valid), 32'h2);
    chk("t1_ch1_data", 32'(out_data[31:16]), 32'hC123);
    chk("t1_ch0_data", 32'(out_data[15:0]), 32'h0);
    drain(2'b10, 1);

    // 2. priority, then no selection
    send(16'h4001, 4'b1010, 1'b1, 0);
    chk("t2_out_valid", 32'(out_valid), 32'h1);
    drain(2'b01, 1);
    send(16'h8002, 4'b0000, 1'b0, -1);
    chk("t2_nosel_valid", 32'(out_valid), 32'h0);
    chk("t2_nosel_drop", 32'(drop_cnt), 32'h0);

    // 3. null absorb and saturation
    repeat (3) send(16'h0FFF, 4'b0000, 1'b1, -1);
    chk("t3_drop3", 32'(drop_cnt), 32'd3);
    chk("t3_out_valid", 32'(out_valid), 32'h0);
    repeat (257) send(16'h0FFF, 4'b0000, 1'b1, -1);
    chk("t3_drop_sat", 32'(drop_cnt), 32'd255);

    // 4. full and back-pressure on ch0
    for (int k = 0; k < 4; k++)
      send(16'h4000 + 16'(k), 4'b0010, 1'b1, 0);
    chk("t4_ch_full", 32'(ch_full), 32'h1);
    mem_valid = 1'b1; mem_data = 16'h4004; ph = 4'b0010;
    @(negedge clk);
    chk("t4_full_rdy", 32'(mem_ready), 32'h0);
    tick();
    out_ready = 2'b01;
    @(negedge clk);
    chk("t4_pop_rdy", 32'(mem_ready), 32'h0);
    tick();
    out_ready = 2'b00;
    @(negedge clk);
    chk("t4_rise_rdy", 32'(mem_ready), 32'h1);
    q0.push_back(16'h4004);
    tick();
    mem_valid = 1'b0;
    drain(2'b01, 4);
    chk("t4_empty", 32'(out_valid), 32'h0);
    chk("t4_q0_left", 32'(q0.size()), 32'h0);

    // 5. simultaneous push/pop on ch1 with pointer wrap
    out_ready = 2'b10;
    for (int k = 0; k < 10; k++) begin
      send(16'h8100 + 16'(k), 4'b1000, 1'b1, 1);
      chk("t5_not_full", 32'(ch_full), 32'h0);
      chk("t5_valid", 32'(out_valid), 32'h2);
    end
    tick();
    chk("t5_drained", 32'(out_valid), 32'h0);
    out_ready = 2'b00;
    chk("t5_q1_left", 32'(q1.size()), 32'h0);

    // 6. reset mid-operation
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_drop_clr", 32'(drop_cnt), 32'h0);
    repeat (5) send(16'h0ABC, 4'b0000, 1'b1, -1);
    for (int k = 0; k < 3; k++)
      send(16'h4700 + 16'(k), 4'b0010, 1'b1, 0);
    chk("t6_drop5", 32'(drop_cnt), 32'd5);
    chk("t6_pre_valid", 32'(out_valid), 32'h1);
    rst = 1'b1; mem_valid = 1'b1;
    mem_data = 16'h4777; ph = 4'b0010;
    @(negedge clk);
    chk("t6_rst_rdy", 32'(mem_ready), 32'h0);
    tick();
    rst = 1'b0; mem_valid = 1'b0;
    q0.delete();
    chk("t6_out_valid", 32'(out_valid), 32'h0);
    chk("t6_drop", 32'(drop_cnt), 32'h0);
    chk("t6_ch_full", 32'(ch_full), 32'h0);
    chk("t6_out_data", out_data, 32'h0);
    tick();
    chk("t6_not_stored", 32'(out_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_out_router.md
# mem_out_router

Parametrised, clocked successor to the two-way memory output demux: routes each word returned by memory to one of `NCH` consumer channels (cache, instruction fetch, further ports), selected by per-channel phase codes. Each channel has a `DEPTH`-entry buffer with a valid/ready handshake, so memory is back-pressured only by the addressed channel. Null words (tag bits `00`) are absorbed and counted, never forwarded. Sits between the memory read port and the cache/fetch units.

## Interface
Parameters:
- `NCH`, default 2: number of output channels, range 2..8.
- `W`, default 16: word width, at least 4. The top two bits are the tag.
- `DEPTH`, default 4: per-channel buffer entries, a power of two, at least 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `mem_data` in `W`: word from memory.
- `mem_valid` in 1: `mem_data` is presented.
- `mem_ready` out 1: router accepts the word this cycle.
- `ph` in `2*NCH`: phase code of channel i is `ph[2i+1:2i]`. Code `2'b10` means channel i is requesting.
- `out_data` out `NCH*W`: head word of channel i in slice `[W*i +: W]`.
- `out_valid` out `NCH`: channel i head is valid.
- `out_ready` in `NCH`: channel i consumer takes its head.
- `ch_full` out `NCH`: channel i buffer is full.
- `drop_cnt` out 8: saturating count of null words absorbed.

## Operation
- **Null detection:** a word is null when `mem_data[W-1:W-2] == 2'b00`.
- **Channel select:** the selected channel is the lowest index i with `ph` code `2'b10`. If no channel requests, there is no selection.
- **mem_ready rules:**
  - If `mem_valid` and the word is null, `mem_ready` is 1, independent of `ph`.
  - If `mem_valid` and the word is not null, `mem_ready` is the inverse of the selected channel's `ch_full`.
  - If the word is not null and there is no selection, `mem_ready` is 0; the word is held by the memory side.
  - If `mem_valid` is 0, `mem_ready` is 0.
- **Accept:** a word is accepted when `mem_valid && mem_ready`. A non-null accepted word is pushed into the selected channel. A null accepted word increments `drop_cnt`, which saturates at 255.
- **Pop:** channel i pops when `out_valid[i] && out_ready[i]`.
- **Full channel:** `mem_ready` is a function of `ch_full` only, never of a same-cycle pop. A full channel therefore refuses a push even while it is popping.
- **Simultaneous push and pop:** on a non-full channel, both take effect and the count is unchanged.
- **Buffer behaviour:**
  - Order is FIFO per channel.
  - Read and write pointers are `log2(DEPTH)` bits and wrap modulo `DEPTH`.
  - Count is `log2(DEPTH)+1` bits.
  - `ch_full[i]` is asserted when count equals `DEPTH`.
  - `out_valid[i]` is asserted when count is non-zero.
- **Empty channel:** `out_data` slice reads 0 whenever the channel's `out_valid` bit is 0.
- **Reset state (applied at the clock edge while `rst` is high, including mid-transfer):**
  - All buffers emptied.
  - `out_valid` = 0, `out_data` = 0, `ch_full` = 0, `drop_cnt` = 0.
  - `mem_ready` forced to 0 while `rst` is high.
  - A word offered during reset is not accepted.

## Timing
- Push to `out_valid`: 1 cycle. A word accepted at edge k is visible at the channel head after edge k.
- `mem_ready` is combinational from `mem_valid`, `mem_data` tag, `ph` and registered `ch_full`. There is no path from `out_ready` to `mem_ready`.
- `out_valid`, `out_data`, `ch_full` and `drop_cnt` derive from registers only.
- Throughput: one word per cycle per router. Each channel drains at one word per cycle.
- `drop_cnt` updates on the accepting edge.

## Structure
- Shared package `mem_route_pkg`:
  - `PH_REQ = 2'b10`.
  - `TAG_NULL = 2'b00`.
  - Drop-counter width constant (8).
- Sub-module `sync_fifo`, parametrised on `W` and `DEPTH`, instantiated `NCH` times via a generate loop.
  - Ports: `push`, `pop`, `din`, `dout`, `full`, `empty`.
  - `dout` is zeroed when empty.
- Top level holds the priority select, null detection, ready logic and drop counter.

## Test plan
Bench configuration is `NCH`=2, `W`=16, `DEPTH`=4.
1. **Basic route:** `ph`=`4'b1000` (ch1 requests), `mem_data`=`16'hC123` valid one cycle. `mem_ready` is 1. After the next edge, `out_valid`=`2'b10` and ch1 `out_data`=`16'hC123`; ch0 stays empty with data 0.
2. **Priority and no-select:** `ph`=`4'b1010` with word `16'h4001`: the word goes to ch0 only. `ph`=`4'b0000` with word `16'h8002`: `mem_ready`=0, nothing pushed, `drop_cnt` stays 0.
3. **Null absorb:** with `ph`=`4'b0000`, send three words `16'h0FFF`. `mem_ready` is 1 each cycle, `drop_cnt`=3, both `out_valid` bits 0. After 260 null words, `drop_cnt`=255.
4. **Full / back-pressure:** with ch0 `out_ready`=0, push `16'h4000` through `16'h4004`. The first four are accepted, `ch_full[0]`=1, and the fifth sees `mem_ready`=0. Assert `out_ready[0]` for one cycle: `16'h4000` pops and `mem_ready` rises the following cycle. Drained order is `16'h4000`..`16'h4004`.
5. **Simultaneous push/pop and wrap:** stream 10 words to ch1 with `out_ready[1]`=1 held. Output order matches input order, the count never exceeds 1, and the pointers wrap twice without loss.
6. **Mid-operation reset:** with ch0 holding 3 words and `drop_cnt`=5, pulse `rst` for one cycle while `mem_valid`=1. `mem_ready` is 0 during reset. After the edge, all `out_valid` are 0, `drop_cnt`=0, and the offered word is not stored.
